// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - run enable plus fetch/display timing outputs of the VGA timing generator
interface vga_timing_gen_if #(
    parameter int COORD_W = 11
);
    logic               en;
    logic [COORD_W-1:0] fetch_x;
    logic [COORD_W-1:0] fetch_y;
    logic               fetch_valid;
    logic               frame_start;
    logic               line_start;
    logic               vblank;
    logic               h_sync;
    logic               v_sync;
    logic               disp_en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    modport master (
        input  en,
        output fetch_x, fetch_y, fetch_valid, frame_start, line_start, vblank,
        output h_sync, v_sync, disp_en, x, y
    );

    modport slave (
        output en,
        input  fetch_x, fetch_y, fetch_valid, frame_start, line_start, vblank,
        input  h_sync, v_sync, disp_en, x, y
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with early fetch and delayed display stages
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter logic H_POL    = 1'b0,
    parameter int   V_ACTIVE = 400,
    parameter int   V_FP     = 12,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 35,
    parameter logic V_POL    = 1'b1,
    parameter int   COORD_W  = 11,
    parameter int   PIPE_DLY = 2
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int FW      = 2 * COORD_W + 4;
    localparam int DW      = 2 * COORD_W + 3;

    localparam logic [DW-1:0] DISP_IDLE = {~H_POL, ~V_POL, 1'b0, {(2 * COORD_W){1'b0}}};

    if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_pipe_dly
        $error("vga_timing_gen: PIPE_DLY must lie in 0..8");
    end
    if ((H_TOTAL - 1) >= (1 << COORD_W) || (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_bad_coord_w
        $error("vga_timing_gen: COORD_W cannot hold H_TOTAL-1 / V_TOTAL-1");
    end

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               h_wrap, v_wrap;
    logic               h_act, v_act, h_in_sync, v_in_sync, act;
    logic [COORD_W-1:0] x_d, y_d;
    logic [FW-1:0]      fetch_d, fetch_q;
    logic [DW-1:0]      disp_d;
    logic [DW-1:0]      dly_q [PIPE_DLY+1];

    // Region decode in int domain so a sync end equal to 2**COORD_W cannot alias to 0.
    assign h_wrap    = int'(h_cnt_q) == H_TOTAL - 1;
    assign v_wrap    = int'(v_cnt_q) == V_TOTAL - 1;
    assign h_act     = int'(h_cnt_q) < H_ACTIVE;
    assign v_act     = int'(v_cnt_q) < V_ACTIVE;
    assign h_in_sync = int'(h_cnt_q) >= H_SS && int'(h_cnt_q) < H_SS + H_SYNC;
    assign v_in_sync = int'(v_cnt_q) >= V_SS && int'(v_cnt_q) < V_SS + V_SYNC;
    assign act       = h_act && v_act;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (!vif.en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        fetch_d = '0;
        disp_d  = DISP_IDLE;
        x_d     = act ? h_cnt_q : '0;
        y_d     = act ? v_cnt_q : '0;
        if (vif.en) begin
            fetch_d = {h_cnt_q, v_cnt_q, act,
                       (h_cnt_q == '0) && (v_cnt_q == '0),
                       (h_cnt_q == '0) && v_act,
                       !v_act};
            disp_d  = {h_in_sync ? H_POL : ~H_POL,
                       v_in_sync ? V_POL : ~V_POL,
                       act, x_d, y_d};
        end
    end

    // Stage 0 of the delay line is aligned with the fetch registers; the rest add PIPE_DLY clocks.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            fetch_q <= '0;
            for (int i = 0; i <= PIPE_DLY; i++) begin
                dly_q[i] <= DISP_IDLE;
            end
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            fetch_q  <= fetch_d;
            dly_q[0] <= disp_d;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign {vif.fetch_x, vif.fetch_y, vif.fetch_valid,
            vif.frame_start, vif.line_start, vif.vblank} = fetch_q;
    assign {vif.h_sync, vif.v_sync, vif.disp_en, vif.x, vif.y} = dly_q[PIPE_DLY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on a 16x8 geometry
module tb_vga_timing_gen;
    localparam int CW = 5;
    localparam logic [12:0] A_IDLE = 13'h1000;
    localparam logic [12:0] B_IDLE = 13'h0800;

    typedef struct {
        int k;
        int fx, fy;
        bit fv, fs, ls, vb;
        bit ahs, avs, ade;
        int ax, ay;
        bit bhs, bvs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   passed = 0;
    int   total  = 0;

    vga_timing_gen_if #(.COORD_W(CW)) ifa ();
    vga_timing_gen_if #(.COORD_W(CW)) ifb ();
    assign ifa.en = en;
    assign ifb.en = en;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .H_POL(1'b0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(1'b1),
        .COORD_W(CW), .PIPE_DLY(2)
    ) dut_a (.pixel_clk(clk), .reset_n(rst_n), .vif(ifa.master));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .H_POL(1'b1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(1'b0),
        .COORD_W(CW), .PIPE_DLY(0)
    ) dut_b (.pixel_clk(clk), .reset_n(rst_n), .vif(ifb.master));

    always #5 clk = ~clk;

    logic [2*CW+3:0] fa;
    logic [2*CW+2:0] da, db;
    assign fa = {ifa.fetch_x, ifa.fetch_y, ifa.fetch_valid, ifa.frame_start, ifa.line_start, ifa.vblank};
    assign da = {ifa.h_sync, ifa.v_sync, ifa.disp_en, ifa.x, ifa.y};
    assign db = {ifb.h_sync, ifb.v_sync, ifb.disp_en, ifb.x, ifb.y};

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void add(input int k, input int fx, input int fy, input bit fv, input bit fs,
                                input bit ls, input bit vb, input bit ahs, input bit avs, input bit ade,
                                input int ax, input int ay, input bit bhs, input bit bvs);
        vec_t v;
        v.k = k; v.fx = fx; v.fy = fy; v.fv = fv; v.fs = fs; v.ls = ls; v.vb = vb;
        v.ahs = ahs; v.avs = avs; v.ade = ade; v.ax = ax; v.ay = ay; v.bhs = bhs; v.bvs = bvs;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0]   hfx [0:300];
        logic [CW-1:0]   hfy [0:300];
        bit              hfv [0:300];
        logic [2*CW+3:0] ef;
        logic [2*CW+2:0] ea, eb;
        int ti, n_ls, n_ls_bad, n_fv, n_ahs, n_bhs, n_avs, n_bvs, n_ade, n_bde;
        int viol_a, viol_b, viol_z;
        int fs_k[$];
        bit found;

        // k, fetch(x,y,valid,fs,ls,vb), A display(hs,vs,de,x,y), B sync(hs,vs)
        add(  1,  0, 0, 1, 1, 1, 0,  1, 0, 0, 0, 0,  0, 1);
        add(  2,  1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1);
        add(  3,  2, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0,  0, 1);
        add(  6,  5, 0, 1, 0, 0, 0,  1, 0, 1, 3, 0,  0, 1);
        add( 10,  9, 0, 0, 0, 0, 0,  1, 0, 1, 7, 0,  0, 1);
        add( 11, 10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1);
        add( 13, 12, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1);
        add( 15, 14, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
        add( 16, 15, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1);
        add( 17,  0, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0,  0, 1);
        add( 19,  2, 1, 1, 0, 0, 0,  1, 0, 1, 0, 1,  0, 1);
        add( 22,  5, 1, 1, 0, 0, 0,  1, 0, 1, 3, 1,  0, 1);
        add( 65,  0, 4, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 1);
        add( 83,  2, 5, 0, 0, 0, 1,  1, 1, 0, 0, 0,  0, 0);
        add(109, 12, 6, 0, 0, 0, 1,  0, 1, 0, 0, 0,  1, 0);
        add(113,  0, 7, 0, 0, 0, 1,  1, 1, 0, 0, 0,  0, 1);
        add(115,  2, 7, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 1);
        add(128, 15, 7, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 1);
        add(129,  0, 0, 1, 1, 1, 0,  1, 0, 0, 0, 0,  0, 1);
        add(131,  2, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0,  0, 1);
        add(134,  5, 0, 1, 0, 0, 0,  1, 0, 1, 3, 0,  0, 1);

        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset fetch", 32'(fa), 32'h0);
        check("reset disp A", 32'(da), 32'(A_IDLE));
        check("reset disp B", 32'(db), 32'(B_IDLE));

        rst_n = 1'b1;
        ti = 0; n_ls = 0; n_ls_bad = 0; n_fv = 0; n_ahs = 0; n_bhs = 0; n_avs = 0; n_bvs = 0;
        n_ade = 0; n_bde = 0; viol_a = 0; viol_b = 0; viol_z = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            hfx[k] = ifa.fetch_x;
            hfy[k] = ifa.fetch_y;
            hfv[k] = ifa.fetch_valid;
            if (ti < tbl.size() && tbl[ti].k == k) begin
                ef = {CW'(tbl[ti].fx), CW'(tbl[ti].fy), tbl[ti].fv, tbl[ti].fs, tbl[ti].ls, tbl[ti].vb};
                ea = {tbl[ti].ahs, tbl[ti].avs, tbl[ti].ade, CW'(tbl[ti].ax), CW'(tbl[ti].ay)};
                eb = {tbl[ti].bhs, tbl[ti].bvs, tbl[ti].fv,
                      tbl[ti].fv ? CW'(tbl[ti].fx) : CW'(0), tbl[ti].fv ? CW'(tbl[ti].fy) : CW'(0)};
                check($sformatf("fetch k=%0d", k), 32'(fa), 32'(ef));
                check($sformatf("disp A k=%0d", k), 32'(da), 32'(ea));
                check($sformatf("disp B k=%0d", k), 32'(db), 32'(eb));
                ti++;
            end
            if (ifa.frame_start) fs_k.push_back(k);
            if (ifa.line_start) begin
                n_ls++;
                if (ifa.fetch_y >= 4) n_ls_bad++;
            end
            if (ifa.fetch_valid) n_fv++;
            if (!ifa.h_sync) n_ahs++;
            if (ifb.h_sync) n_bhs++;
            if (ifa.v_sync) n_avs++;
            if (!ifb.v_sync) n_bvs++;
            if (ifa.disp_en) n_ade++;
            if (ifb.disp_en) n_bde++;
            if (k >= 3) begin
                ea = {!(hfx[k-2] >= 10 && hfx[k-2] <= 12), (hfy[k-2] >= 5 && hfy[k-2] <= 6), hfv[k-2],
                      hfv[k-2] ? hfx[k-2] : CW'(0), hfv[k-2] ? hfy[k-2] : CW'(0)};
                if (da !== ea) viol_a++;
            end
            eb = {(hfx[k] >= 10 && hfx[k] <= 12), !(hfy[k] >= 5 && hfy[k] <= 6), hfv[k],
                  hfv[k] ? hfx[k] : CW'(0), hfv[k] ? hfy[k] : CW'(0)};
            if (db !== eb) viol_b++;
            if (!ifa.disp_en && (ifa.x != 0 || ifa.y != 0)) viol_z++;
            if (!ifb.disp_en && (ifb.x != 0 || ifb.y != 0)) viol_z++;
        end
        check("table entries applied", ti, tbl.size());
        check("frame_start count", fs_k.size(), 2);
        check("frame_start period", (fs_k.size() == 2) ? fs_k[1] - fs_k[0] : -1, 128);
        check("line_start count", n_ls, 8);
        check("line_start outside active", n_ls_bad, 0);
        check("fetch_valid count", n_fv, 64);
        check("A h_sync active count", n_ahs, 48);
        check("B h_sync active count", n_bhs, 48);
        check("A v_sync active count", n_avs, 64);
        check("B v_sync active count", n_bvs, 64);
        check("A disp_en count", n_ade, 64);
        check("B disp_en count", n_bde, 64);
        check("A two-clock alignment errors", viol_a, 0);
        check("B zero-lag alignment errors", viol_b, 0);
        check("x/y nonzero in blanking", viol_z, 0);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ifa.fetch_x == 5 && ifa.fetch_y == 2) found = 1'b1;
        end
        check("reach fetch (5,2)", 32'(found), 32'h1);
        check("disp A at drop", 32'(da), 32'({1'b1, 1'b0, 1'b1, CW'(3), CW'(2)}));
        en = 1'b0;
        @(negedge clk);
        check("en drop fetch idle", 32'(fa), 32'h0);
        check("en drop B idle", 32'(db), 32'(B_IDLE));
        check("en drop A +1", 32'(da), 32'({1'b1, 1'b0, 1'b1, CW'(4), CW'(2)}));
        @(negedge clk);
        check("en drop A +2", 32'(da), 32'({1'b1, 1'b0, 1'b1, CW'(5), CW'(2)}));
        @(negedge clk);
        check("en drop A +3 idle", 32'(da), 32'(A_IDLE));
        repeat (3) @(negedge clk);
        check("en low fetch held idle", 32'(fa), 32'h0);
        en = 1'b1;
        @(negedge clk);
        check("en rise frame_start", 32'(fa), 32'({CW'(0), CW'(0), 4'b1110}));
        @(negedge clk);
        check("en rise second fetch", 32'(fa), 32'({CW'(1), CW'(0), 4'b1000}));
        @(negedge clk);
        check("en rise A first pixel", 32'(da), 32'({1'b1, 1'b0, 1'b1, CW'(0), CW'(0)}));

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset fetch", 32'(fa), 32'h0);
        check("async reset A idle", 32'(da), 32'(A_IDLE));
        check("async reset B idle", 32'(db), 32'(B_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset frame_start", 32'(fa), 32'({CW'(0), CW'(0), 4'b1110}));
        @(negedge clk);
        @(negedge clk);
        check("post-reset A first pixel", 32'(da), 32'({1'b1, 1'b0, 1'b1, CW'(0), CW'(0)}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x400 sync controller.
- Adds per-axis sync polarity, configurable coordinate width, and an enable.
- Produces an early "fetch" coordinate stream for the framebuffer/character-ROM pipeline, plus display-aligned sync/DE/coordinates delayed by PIPE_DLY cycles to match fetch latency.
- Also emits frame_start, line_start and vblank for CPU interrupts and DMA.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- H_POL, 0, h_sync active level
- V_ACTIVE, 400, visible lines per frame
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BP, 35, vertical back porch (lines)
- V_POL, 1, v_sync active level
- COORD_W, 11, width of counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1
- PIPE_DLY, 2, extra cycles from fetch stage to display stage; legal range 0..8

Ports:
- pixel_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 holds the generator idle at (0,0)
- fetch_x  out  COORD_W  column being fetched
- fetch_y  out  COORD_W  line being fetched
- fetch_valid  out  1  fetch_x/fetch_y lie in the active area
- frame_start  out  1  one-cycle pulse at fetch position (0,0)
- line_start  out  1  one-cycle pulse at fetch_x=0 on an active line
- vblank  out  1  fetch_y >= V_ACTIVE
- h_sync  out  1  display-stage horizontal sync
- v_sync  out  1  display-stage vertical sync
- disp_en  out  1  display-stage active video
- x  out  COORD_W  display-stage column; 0 when disp_en=0
- y  out  COORD_W  display-stage line; 0 when disp_en=0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters h_cnt/v_cnt:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments only when h_cnt wraps; it wraps 0..V_TOTAL-1.
  - Wrap on equality to TOTAL-1, not on overflow.
- Horizontal regions: active h<H_ACTIVE; FP H_ACTIVE..H_ACTIVE+H_FP-1; sync H_ACTIVE+H_FP..H_ACTIVE+H_FP+H_SYNC-1 (exactly H_SYNC clocks); BP the remainder.
- Vertical regions: identical rule using v_cnt; sync lasts exactly V_SYNC whole lines.
- Sync level: h_sync=H_POL inside the horizontal sync region, !H_POL elsewhere; v_sync likewise with V_POL.
- Fetch stage: registered from counter state, so one clock of latency. At the edge after counters=(h,v):
  - fetch_x=h, fetch_y=v
  - fetch_valid = (h<H_ACTIVE && v<V_ACTIVE)
  - frame_start = (h==0 && v==0)
  - line_start = (h==0 && v<V_ACTIVE)
  - vblank = (v>=V_ACTIVE)
  - fetch_x/fetch_y track the raw counters in all regions (blanking included).
- Display stage: shift register PIPE_DLY deep carrying {h_sync, v_sync, disp_en, x, y}. Total latency from counter state to display outputs is 1+PIPE_DLY clocks. PIPE_DLY=0 means display outputs are registered alongside the fetch outputs.
- x/y at display stage: equal the delayed fetch coordinates when disp_en=1, forced to 0 otherwise.
- Reset (reset_n=0, asynchronous):
  - h_cnt=v_cnt=0
  - fetch_x=fetch_y=0; fetch_valid, frame_start, line_start, vblank = 0
  - every delay-line entry and display output idle: h_sync=!H_POL, v_sync=!V_POL, disp_en=0, x=y=0
  - reset release: the first rising edge with en=1 produces frame_start=1 at (0,0).
- en=0 (synchronous):
  - counters load 0 and hold.
  - fetch-stage outputs take their reset values.
  - the delay line keeps shifting idle values in, so display outputs reach idle PIPE_DLY clocks later (no torn pulses).
- en rising: the counters begin from (0,0) on the next edge, so the first fetch output is frame_start=1, fetch_valid=1.
- en dropped mid-frame: the frame is abandoned. No partial-frame resume.
- Simultaneous h-wrap and v-wrap: both counters return to 0 on the same edge. The following fetch output is frame_start=1, line_start=1.
- Illegal PIPE_DLY (>8) or COORD_W too small: elaboration error via generate-time check.

Test Plan:
- Small geometry (H 8/2/3/3, V 4/1/2/1; H_TOTAL=16, V_TOTAL=8, PIPE_DLY=2), release reset with en=1 -> frame_start every 128 clocks; line_start at fetch_y 0..3 only; fetch_valid high for 32 clocks per frame.
- Same config, horizontal sync check -> h_sync=H_POL for exactly 3 clocks, spanning display-stage h 10..12, on all 8 lines; v_sync=V_POL for exactly 32 clocks (lines 5..6).
- Alignment -> disp_en, x, y lag fetch_valid, fetch_x, fetch_y by exactly 2 clocks; x=y=0 whenever disp_en=0; PIPE_DLY=0 rerun gives zero lag.
- Wrap -> after fetch (15,7) the next cycle is fetch (0,0) with frame_start=1, line_start=1, vblank=0.
- en deasserted at fetch (5,2) -> fetch outputs idle the next clock; display outputs idle after 2 more clocks; re-asserting en -> frame_start on the first edge, fetch (0,0).
- reset_n pulsed low mid-line with en=1 -> all outputs idle immediately without waiting for a clock edge; frame restarts at (0,0) after release; H_POL=1/V_POL=0 variant shows inverted idle levels.
